stream_arb_mux: RTL and testbench

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes. It merges several requesters (e.g. instruction fetch, data load/store, debug) onto one shared memory/bus port. Multi-beat transfers are never interleaved: a burst holds the grant until its last beat. One pipeline register decouples input selection from the downstream port.

---
 rtl/stream_arb_mux.sv | 134 +++++++++++++
 tb/tb_stream_arb_mux.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux.sv
// stream_arb_mux
//   N-channel arbitrating multiplexer with a registered output slice.
//   It merges several valid/ready requesters onto one downstream port.
//   A multi-beat burst keeps the grant until its last beat, so bursts
//   from different channels never interleave.
//
// Parameters
//   N   number of input channels (at least 1)
//   W   payload width in bits
//   RR  1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
//   IW  channel index width (derived)
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   [N]    per-channel request valid
//   in_data    [N*W]  channel i payload in bits [i*W +: W]
//   in_last    [N]    per-channel last-beat flag
//   in_ready   [N]    per-channel accept (one-hot or zero)
//   out_valid         output register holds a beat
//   out_data   [W]    registered payload
//   out_idx    [IW]   source channel of the registered beat
//   out_last          registered last flag
//   out_ready         downstream accept
module stream_arb_mux #(
    parameter int N  = 4,
    parameter int W  = 64,
    parameter int RR = 1,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [IW-1:0]   out_idx,
    output logic            out_last,
    input  logic            out_ready
);

    // Arbitration state
    logic [IW-1:0] ptr;     // round-robin scan start
    logic          locked;  // a burst is in progress
    logic [IW-1:0] lidx;    // owner of the current burst

    // Combinational grant
    logic          load;
    logic [IW-1:0] g;
    logic          gvalid;
    logic          xfer;
    logic [W-1:0]  sel_data;
    logic          sel_last;

    // (base + k) mod N without a general modulo; base < N and k < N.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input int unsigned   k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= 32'(N)) s = s - 32'(N);
        return IW'(s);
    endfunction

    assign load = !out_valid || out_ready;

    always_comb begin
        g      = '0;
        gvalid = 1'b0;
        if (locked) begin
            // The burst owner keeps the grant even while it is idle.
            g      = lidx;
            gvalid = in_valid[lidx];
        end else if (RR != 0) begin
            for (int unsigned k = 0; k < 32'(N); k++) begin
                if (!gvalid && in_valid[wrap_add(ptr, k)]) begin
                    g      = wrap_add(ptr, k);
                    gvalid = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < 32'(N); k++) begin
                if (!gvalid && in_valid[k]) begin
                    g      = IW'(k);
                    gvalid = 1'b1;
                end
            end
        end
    end

    // rstn gates the accept so nothing is offered while reset is held.
    assign xfer = rstn && load && gvalid;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[g] = 1'b1;
    end

    // Payload select uses constant slices so in_ready never depends on data.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned k = 0; k < 32'(N); k++) begin
            if (IW'(k) == g) begin
                sel_data = in_data[k*W +: W];
                sel_last = in_last[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
            locked    <= 1'b0;
            lidx      <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_idx  <= g;
                out_last <= sel_last;
                locked   <= !sel_last;
                if (!sel_last) lidx <= g;
                if (RR != 0 && sel_last) ptr <= wrap_add(g, 1);
            end
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
module tb_stream_arb_mux;

    logic          clk = 1'b0;
    logic          rstn;
    logic [3:0]    in_valid;
    logic [255:0]  in_data;
    logic [3:0]    in_last;
    logic          out_ready;

    logic [3:0]    rdy_rr, rdy_fp;
    logic          ov_rr, ov_fp, ol_rr, ol_fp;
    logic [63:0]   od_rr, od_fp;
    logic [1:0]    oi_rr, oi_fp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_arb_mux #(.N(4), .W(64), .RR(1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_rr), .out_valid(ov_rr),
        .out_data(od_rr), .out_idx(oi_rr), .out_last(ol_rr),
        .out_ready(out_ready)
    );

    stream_arb_mux #(.N(4), .W(64), .RR(0)) dut_fp (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy_fp), .out_valid(ov_fp),
        .out_data(od_fp), .out_idx(oi_fp), .out_last(ol_fp),
        .out_ready(out_ready)
    );

    typedef struct {
        logic        sel;    // 0: round-robin instance, 1: fixed-priority
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;      // one byte per channel, replicated to 64 bits
        logic        ordy;
        logic [3:0]  erdy;
        logic        eov;
        logic [1:0]  eidx;
        logic [7:0]  eb;
        logic        elast;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic sel, input logic [3:0] v,
                                input logic [3:0] l, input logic [31:0] d,
                                input logic ordy, input logic [3:0] erdy,
                                input logic eov, input logic [1:0] eidx,
                                input logic [7:0] eb, input logic elast);
        vec_t t;
        t.sel = sel; t.v = v; t.l = l; t.d = d; t.ordy = ordy;
        t.erdy = erdy; t.eov = eov; t.eidx = eidx; t.eb = eb; t.elast = elast;
        tv.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic ordy);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int c = 0; c < 4; c++) in_data[c*64 +: 64] = {8{d[c*8 +: 8]}};
    endtask

    initial begin
        rstn = 1'b0;
        drive(4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1);

        // Round-robin: all channels valid with single beats
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 0, 8'hA0, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 1, 1, 8'hA1, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 1, 2, 8'hA2, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 1, 3, 8'hA3, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 0, 8'hA0, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 1, 1, 8'hA1, 1);
        // Backpressure: out_ready 1,0,0,1
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 1, 2, 8'hA2, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 0, 4'b0000, 1, 2, 8'hA2, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 0, 4'b0000, 1, 2, 8'hA2, 1);
        add(0, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 1, 3, 8'hA3, 1);
        // Drain: out_valid falls, payload retained
        add(0, 4'b0000, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 3, 8'hA3, 1);
        add(0, 4'b0000, 4'b1111, 32'hA3A2A1A0, 1, 4'b0000, 0, 3, 8'hA3, 1);
        // Move the pointer to 2, then channel 2 bursts while channel 0 waits
        add(0, 4'b0010, 4'b0010, 32'h00001100, 1, 4'b0010, 1, 1, 8'h11, 1);
        add(0, 4'b0101, 4'b0001, 32'h00210001, 1, 4'b0100, 1, 2, 8'h21, 0);
        add(0, 4'b0101, 4'b0001, 32'h00220001, 1, 4'b0100, 1, 2, 8'h22, 0);
        add(0, 4'b0101, 4'b0101, 32'h00230001, 1, 4'b0100, 1, 2, 8'h23, 1);
        add(0, 4'b0001, 4'b0001, 32'h00000001, 1, 4'b0001, 1, 0, 8'h01, 1);
        // Second burst with a two-cycle gap on channel 2
        add(0, 4'b0101, 4'b0001, 32'h00310001, 1, 4'b0100, 1, 2, 8'h31, 0);
        add(0, 4'b0001, 4'b0001, 32'h00320001, 1, 4'b0000, 0, 2, 8'h31, 0);
        add(0, 4'b0001, 4'b0001, 32'h00320001, 1, 4'b0000, 0, 2, 8'h31, 0);
        add(0, 4'b0101, 4'b0001, 32'h00320001, 1, 4'b0100, 1, 2, 8'h32, 0);
        add(0, 4'b0101, 4'b0101, 32'h00330001, 1, 4'b0100, 1, 2, 8'h33, 1);
        add(0, 4'b0001, 4'b0001, 32'h00000001, 1, 4'b0001, 1, 0, 8'h01, 1);
        // Fixed priority: channels 1 and 3 valid, channel 1 always wins
        add(1, 4'b1010, 4'b1111, 32'h43004100, 1, 4'b0010, 1, 1, 8'h41, 1);
        add(1, 4'b1010, 4'b1111, 32'h43004200, 1, 4'b0010, 1, 1, 8'h42, 1);
        add(1, 4'b1010, 4'b1111, 32'h43004400, 1, 4'b0010, 1, 1, 8'h44, 1);

        // Reset held: nothing offered, outputs clear
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy_rr", 64'(rdy_rr), 64'h0);
        chk("rst_rdy_fp", 64'(rdy_fp), 64'h0);
        chk("rst_ov_rr", 64'(ov_rr), 64'h0);
        chk("rst_ov_fp", 64'(ov_fp), 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].l, tv[i].d, tv[i].ordy);
            #1;
            chk($sformatf("row%0d_rdy", i), 64'(tv[i].sel ? rdy_fp : rdy_rr), 64'(tv[i].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_ov", i), 64'(tv[i].sel ? ov_fp : ov_rr), 64'(tv[i].eov));
            chk($sformatf("row%0d_idx", i), 64'(tv[i].sel ? oi_fp : oi_rr), 64'(tv[i].eidx));
            chk($sformatf("row%0d_data", i), tv[i].sel ? od_fp : od_rr, {8{tv[i].eb}});
            chk($sformatf("row%0d_last", i), 64'(tv[i].sel ? ol_fp : ol_rr), 64'(tv[i].elast));
        end

        // Reset in the middle of a burst from channel 1
        drive(4'b0010, 4'b0000, 32'h00005500, 1'b1);
        #1;
        chk("mb_rdy", 64'(rdy_rr), 64'h2);
        @(posedge clk);
        #1;
        chk("mb_ov", 64'(ov_rr), 64'h1);
        chk("mb_last", 64'(ol_rr), 64'h0);
        #2;
        rstn = 1'b0;
        drive(4'b1111, 4'b1111, 32'hA3A2A1A0, 1'b1);
        #1;
        chk("mbrst_ov", 64'(ov_rr), 64'h0);
        chk("mbrst_rdy", 64'(rdy_rr), 64'h0);
        chk("mbrst_data", od_rr, 64'h0);
        chk("mbrst_idx", 64'(oi_rr), 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        // Lock dropped and pointer back at 0: channel 0 wins
        chk("post_rdy", 64'(rdy_rr), 64'h1);
        @(posedge clk);
        #1;
        chk("post_ov", 64'(ov_rr), 64'h1);
        chk("post_idx", 64'(oi_rr), 64'h0);
        chk("post_data", od_rr, {8{8'hA0}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
